// File: rtl/imem_chfifo_ctl_pkg.sv
// Shared definitions for the multi-channel circular FIFO controller and the
// memory instantiation level that sits beside it.
package imem_chfifo_ctl_pkg;

  localparam int CHBIT_DEF  = 5;
  localparam int NCH_DEF    = 21;
  localparam int SEGBIT_DEF = 6;
  localparam int WIDTH_DEF  = 8;
  localparam int RDLAT_DEF  = 3;

  // Outcome of a push or pop request in the current cycle
  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_OK   = 2'd1,
    REQ_DROP = 2'd2,
    REQ_SKIP = 2'd3
  } req_res_e;

  // Number of words in one channel segment
  function automatic int seg_words(input int segbit);
    return 1 << segbit;
  endfunction

endpackage

`ifndef IMEM_CHFIFO_SEG_ADDR
// Physical memory address of word 'off' inside the segment of channel 'ch'
`define IMEM_CHFIFO_SEG_ADDR(ch, off) {(ch), (off)}
`endif

// File: rtl/imem_chfifo_ctl_dlypipe.sv
// Delay line that carries the read-valid flag and its channel tag alongside
// the memory read latency, so the tag lines up with the returned data.
module imem_chfifo_ctl_dlypipe #(
  parameter int DEPTH = 3,
  parameter int CHBIT = 5
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             in_vld,
  input  logic [CHBIT-1:0] in_ch,
  output logic             out_vld,
  output logic [CHBIT-1:0] out_ch
);

  logic [DEPTH-1:0] vld_q;
  logic [CHBIT-1:0] ch_q [DEPTH];

  // Shift {vld, ch} one stage per clock; reset drops anything in flight
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) ch_q[i] <= '0;
    end else begin
      vld_q[0] <= in_vld;
      ch_q[0]  <= in_ch;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
        ch_q[i]  <= ch_q[i-1];
      end
    end
  end

  assign out_vld = vld_q[DEPTH-1];
  assign out_ch  = ch_q[DEPTH-1];

endmodule

// File: rtl/imem_chfifo_ctl.sv
// Multi-channel circular FIFO controller. Each channel owns one segment of
// the shared buffer memory; this block keeps per-channel pointers, turns
// push/pop requests into memory write/read cycles and retags read data.
module imem_chfifo_ctl
  import imem_chfifo_ctl_pkg::*;
#(
  parameter int CHBIT  = CHBIT_DEF,
  parameter int NCH    = NCH_DEF,
  parameter int SEGBIT = SEGBIT_DEF,
  parameter int WIDTH  = WIDTH_DEF,
  parameter int RDLAT  = RDLAT_DEF
) (
  input  logic                    clk,
  input  logic                    rst_,
  input  logic                    wrreq,
  input  logic [CHBIT-1:0]        wrch,
  input  logic [WIDTH-1:0]        wrdat,
  input  logic                    rdreq,
  input  logic [CHBIT-1:0]        rdch,
  output logic [CHBIT+SEGBIT-1:0] mwa,
  output logic                    mwe,
  output logic [WIDTH-1:0]        mdi,
  output logic [CHBIT+SEGBIT-1:0] mra,
  output logic                    mre,
  input  logic [WIDTH-1:0]        mdo,
  output logic                    rdvld,
  output logic [CHBIT-1:0]        rdoch,
  output logic [WIDTH-1:0]        rddat,
  output logic                    ovf,
  output logic                    udf,
  output logic [SEGBIT:0]         lvl,
  input  logic                    chinit
);

  localparam int AW = CHBIT + SEGBIT;
  localparam int PW = SEGBIT + 1;
  localparam logic [PW-1:0]  FULL_LVL = PW'(seg_words(SEGBIT));
  localparam logic [CHBIT:0] NCH_W    = (CHBIT+1)'(NCH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  logic [PW-1:0] wptr [NCH];
  logic [PW-1:0] rptr [NCH];

  logic             wr_in, rd_in;
  logic [CHBIT-1:0] wr_idx, rd_idx;
  logic [PW-1:0]    wr_fill, rd_fill;
  req_res_e         wr_res, rd_res;

  // Classify this cycle's push and pop against the pre-cycle pointers
  always_comb begin
    wr_in   = ({1'b0, wrch} < NCH_W);
    rd_in   = ({1'b0, rdch} < NCH_W);
    wr_idx  = wr_in ? wrch : '0;
    rd_idx  = rd_in ? rdch : '0;
    wr_fill = wptr[wr_idx] - rptr[wr_idx];
    rd_fill = wptr[rd_idx] - rptr[rd_idx];

    wr_res = REQ_NONE;
    if (wrreq) begin
      if (!wr_in)                  wr_res = REQ_SKIP;
      else if (wr_fill == FULL_LVL) wr_res = REQ_DROP;
      else                         wr_res = REQ_OK;
    end

    // A flush on the pop channel swallows the pop silently
    rd_res = REQ_NONE;
    if (rdreq && !chinit) begin
      if (!rd_in)             rd_res = REQ_SKIP;
      else if (rd_fill == '0) rd_res = REQ_DROP;
      else                    rd_res = REQ_OK;
    end
  end

  // Pointer update and registered memory-port / status outputs
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      for (int i = 0; i < NCH; i++) begin
        wptr[i] <= '0;
        rptr[i] <= '0;
      end
      mwe <= 1'b0;
      mwa <= '0;
      mdi <= '0;
      mre <= 1'b0;
      mra <= '0;
      ovf <= 1'b0;
      udf <= 1'b0;
      lvl <= '0;
    end else begin
      mwe <= (wr_res == REQ_OK);
      ovf <= (wr_res == REQ_DROP);
      mre <= (rd_res == REQ_OK);
      udf <= (rd_res == REQ_DROP);
      lvl <= rd_in ? rd_fill : '0;

      if (wr_res == REQ_OK) begin
        mwa            <= `IMEM_CHFIFO_SEG_ADDR(wrch, wptr[wr_idx][SEGBIT-1:0]);
        mdi            <= wrdat;
        wptr[wr_idx]   <= wptr[wr_idx] + 1'b1;
      end

      // Flush uses the pre-cycle wptr, so a same-cycle push stays readable
      if (chinit && rd_in) begin
        rptr[rd_idx] <= wptr[rd_idx];
      end else if (rd_res == REQ_OK) begin
        mra          <= `IMEM_CHFIFO_SEG_ADDR(rdch, rptr[rd_idx][SEGBIT-1:0]);
        rptr[rd_idx] <= rptr[rd_idx] + 1'b1;
      end
    end
  end

  imem_chfifo_ctl_dlypipe #(
    .DEPTH (RDLAT),
    .CHBIT (CHBIT)
  ) u_dlypipe (
    .clk     (clk),
    .rst_    (rst_),
    .in_vld  (mre),
    .in_ch   (mra[AW-1:SEGBIT]),
    .out_vld (rdvld),
    .out_ch  (rdoch)
  );

  assign rddat = rdvld ? mdo : '0;

endmodule

// File: tb/tb_imem_chfifo_ctl.sv
// Bench for imem_chfifo_ctl: a behavioural memory plus per-channel data
// queues predict every memory-port cycle, status pulse and popped word.
module tb_imem_chfifo_ctl;

  localparam int NCH   = 21;
  localparam int DEPTH = 64;
  localparam int RDLAT = 3;

  logic        clk = 1'b0;
  logic        rst_;
  logic        wrreq, rdreq, chinit;
  logic [4:0]  wrch, rdch;
  logic [7:0]  wrdat;
  logic [10:0] mwa, mra;
  logic        mwe, mre;
  logic [7:0]  mdi, mdo, rddat;
  logic        rdvld, ovf, udf;
  logic [4:0]  rdoch;
  logic [6:0]  lvl;

  imem_chfifo_ctl dut (
    .clk(clk), .rst_(rst_),
    .wrreq(wrreq), .wrch(wrch), .wrdat(wrdat),
    .rdreq(rdreq), .rdch(rdch),
    .mwa(mwa), .mwe(mwe), .mdi(mdi),
    .mra(mra), .mre(mre), .mdo(mdo),
    .rdvld(rdvld), .rdoch(rdoch), .rddat(rddat),
    .ovf(ovf), .udf(udf), .lvl(lvl), .chinit(chinit)
  );

  always #5 clk = ~clk;

  // Shared buffer memory with RDLAT clocks of read latency
  logic [7:0] mem [2048];
  logic [7:0] rq  [RDLAT];
  always @(posedge clk) begin
    if (mwe) mem[mwa] <= mdi;
    rq[0] <= mem[mra];
    for (int i = 1; i < RDLAT; i++) rq[i] <= rq[i-1];
  end
  assign mdo = rq[RDLAT-1];

  // Reference model: contents per channel, push/pop totals for addressing
  typedef struct { int due; logic [4:0] ch; logic [7:0] dat; } pend_t;
  logic [7:0] q [NCH][$];
  int         wcnt [NCH];
  int         rcnt [NCH];
  pend_t      pend [$];
  int         cyc = 0;
  int         n_chk = 0;
  int         n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < NCH; c++) begin
      q[c].delete();
      wcnt[c] = 0;
      rcnt[c] = 0;
    end
    pend.delete();
  endtask

  task automatic do_reset();
    wrreq = 0; rdreq = 0; chinit = 0; wrch = 0; rdch = 0; wrdat = 0;
    rst_ = 1'b0;
    #2;
    chk("rst_mwe",   32'(mwe),   0);
    chk("rst_mre",   32'(mre),   0);
    chk("rst_rdvld", 32'(rdvld), 0);
    chk("rst_ovf",   32'(ovf),   0);
    chk("rst_udf",   32'(udf),   0);
    chk("rst_mwa",   32'(mwa),   0);
    chk("rst_mra",   32'(mra),   0);
    chk("rst_mdi",   32'(mdi),   0);
    chk("rst_rdoch", 32'(rdoch), 0);
    chk("rst_rddat", 32'(rddat), 0);
    chk("rst_lvl",   32'(lvl),   0);
    model_clear();
    @(negedge clk);
    rst_ = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // One clock of stimulus, predicted from the model and checked after the edge
  task automatic step(input bit wr, input int wc, input logic [7:0] wd,
                      input bit rd, input int rc, input bit ci);
    bit          e_mwe = 0, e_ovf = 0, e_mre = 0, e_udf = 0, e_v;
    logic [10:0] e_mwa = '0, e_mra = '0;
    int          e_lvl = 0;
    bit          do_push = 0, do_pop = 0, do_flush = 0;

    wrreq = wr; wrch = 5'(wc); wrdat = wd;
    rdreq = rd; rdch = 5'(rc); chinit = ci;

    if (wr && wc < NCH) begin
      if (q[wc].size() == DEPTH) e_ovf = 1;
      else begin
        e_mwe = 1;
        e_mwa = {5'(wc), 6'(wcnt[wc] % DEPTH)};
        do_push = 1;
      end
    end
    if (rc < NCH) begin
      e_lvl = q[rc].size();
      if (ci) do_flush = 1;
      else if (rd) begin
        if (q[rc].size() == 0) e_udf = 1;
        else begin
          e_mre = 1;
          e_mra = {5'(rc), 6'(rcnt[rc] % DEPTH)};
          do_pop = 1;
        end
      end
    end

    if (do_pop) begin
      pend.push_back('{cyc + 1 + RDLAT, 5'(rc), q[rc][0]});
      void'(q[rc].pop_front());
      rcnt[rc]++;
    end
    if (do_flush) begin
      q[rc].delete();
      rcnt[rc] = wcnt[rc];
    end
    if (do_push) begin
      q[wc].push_back(wd);
      wcnt[wc]++;
    end

    @(posedge clk);
    #1;
    cyc++;

    chk("mwe", 32'(mwe), 32'(e_mwe));
    if (e_mwe) begin
      chk("mwa", 32'(mwa), 32'(e_mwa));
      chk("mdi", 32'(mdi), 32'(wd));
    end
    chk("ovf", 32'(ovf), 32'(e_ovf));
    chk("mre", 32'(mre), 32'(e_mre));
    if (e_mre) chk("mra", 32'(mra), 32'(e_mra));
    chk("udf", 32'(udf), 32'(e_udf));
    chk("lvl", 32'(lvl), 32'(e_lvl));

    e_v = (pend.size() > 0) && (pend[0].due == cyc);
    chk("rdvld", 32'(rdvld), 32'(e_v));
    if (e_v) begin
      chk("rdoch", 32'(rdoch), 32'(pend[0].ch));
      chk("rddat", 32'(rddat), 32'(pend[0].dat));
      void'(pend.pop_front());
    end
  endtask

  task automatic idle(input int n, input int rc);
    for (int i = 0; i < n; i++) step(0, 0, 8'h00, 0, rc, 0);
  endtask

  function automatic int pick_ch();
    int r;
    r = int'($urandom_range(0, 5));
    if (r == 5) r = int'($urandom_range(21, 31));
    return r;
  endfunction

  initial begin
    rst_ = 1'b1;
    wrreq = 0; rdreq = 0; chinit = 0; wrch = 0; rdch = 0; wrdat = 0;
    @(posedge clk);
    #1;
    do_reset();

    // Basic push then pop with full read latency
    step(1, 3, 8'hA5, 0, 3, 0);
    idle(1, 3);
    step(0, 0, 8'h00, 1, 3, 0);
    idle(RDLAT + 2, 3);

    // Fill ch0 to capacity, one extra push overflows, then wrap the address
    for (int i = 0; i < DEPTH + 1; i++) step(1, 0, 8'(i * 3 + 1), 0, 0, 0);
    idle(1, 0);
    step(0, 0, 8'h00, 1, 0, 0);
    step(1, 0, 8'h77, 0, 0, 0);
    idle(RDLAT + 1, 0);

    // Pop from empty ch7
    step(0, 0, 8'h00, 1, 7, 0);
    idle(RDLAT + 2, 7);

    // Same-cycle push and pop on ch5 holding one word, then on empty ch5
    step(1, 5, 8'h11, 0, 5, 0);
    step(1, 5, 8'h22, 1, 5, 0);
    step(0, 0, 8'h00, 1, 5, 0);
    idle(1, 5);
    step(1, 5, 8'h33, 1, 5, 0);
    idle(RDLAT + 2, 5);

    // Flush ch2 after 10 words, pop underflows, fresh push is readable
    for (int i = 0; i < 10; i++) step(1, 2, 8'(8'h40 + i), 0, 2, 0);
    step(0, 0, 8'h00, 1, 2, 1);
    step(0, 0, 8'h00, 1, 2, 0);
    step(1, 2, 8'h3C, 0, 2, 0);
    step(0, 0, 8'h00, 1, 2, 0);
    idle(RDLAT + 2, 2);

    // Flush with a concurrent push to the same channel keeps the new word
    step(1, 4, 8'h5A, 0, 4, 0);
    step(1, 4, 8'h5B, 0, 4, 1);
    step(0, 0, 8'h00, 1, 4, 0);
    idle(RDLAT + 2, 4);

    // Out-of-range channels are ignored
    step(1, 21, 8'hEE, 1, 25, 0);
    step(1, 31, 8'hEF, 1, 31, 1);
    idle(2, 0);

    // Randomized traffic on a few channels plus illegal channel indices
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 9) < 7), pick_ch(), 8'($urandom()),
           ($urandom_range(0, 9) < 5), pick_ch(), ($urandom_range(0, 39) == 0));
    end
    idle(RDLAT + 2, 1);

    // Reset while a read is in flight: the pending return must vanish
    step(1, 1, 8'h99, 0, 1, 0);
    step(0, 0, 8'h00, 1, 1, 0);
    do_reset();
    idle(RDLAT + 2, 1);
    step(1, 1, 8'h66, 0, 1, 0);
    step(0, 0, 8'h00, 1, 1, 0);
    idle(RDLAT + 2, 1);

    chk("pend_empty", 32'(pend.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
